pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match-level controller for the Pong game datapath. Sequences the ball block through idle, serve delay, live rally and point handling. Counts each player's score from the ball's `point_1`/`point_2` pulses and declares a winner. Sits between the frame-tick generator, the start button and the ball/bar logic; drives the ball's reset and per-frame advance enable.

## Interface
Parameters:
- `WIN_SCORE`, 9: score that ends the match; legal range 1–15.
- `SERVE_FRAMES`, 60: frame ticks the ball is held at centre before each serve; legal range 1–255.
- `RALLY_FRAMES`, 300: frame ticks of continuous play per speed step; legal range 1–1023. Used only with `PONG_SPEEDUP_EN`.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse, once per video frame.
- `start` in 1: synchronised, debounced start request, level or pulse.
- `point_1` in 1: player 1 scored, from the ball block.
- `point_2` in 1: player 2 scored, from the ball block.
- `ball_rst` out 1: holds the ball at its centre start position.
- `ball_en` out 1: one-cycle enable that advances the ball one frame.
- `score_1` out 4: player 1 score.
- `score_2` out 4: player 2 score.
- `game_over` out 1: match finished.
- `winner` out 1: 0 = player 1, 1 = player 2; valid only while `game_over` = 1.
- `speed` out 2: ball speed level, 0–3.
- `state` out 3: current state encoding, for debug and display.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Encodings 5–7 are illegal and go to IDLE on the next clock.
- IDLE:
  - Outputs: `ball_rst`=1, `ball_en`=0.
  - `start`=1: clear both scores and `speed`, load the serve counter with `SERVE_FRAMES`, go to SERVE.
- SERVE:
  - Outputs: `ball_rst`=1, `ball_en`=0.
  - Each `frame_tick` decrements the serve counter.
  - When the counter is 1 and `frame_tick`=1: go to PLAY and clear the rally counter.
- PLAY:
  - Outputs: `ball_rst`=0; `ball_en` mirrors `frame_tick`, registered.
  - `point_1`=1: increment `score_1`, go to POINT.
  - Else `point_2`=1: increment `score_2`, go to POINT.
  - If both are high in the same cycle, `point_1` wins and `point_2` is dropped.
- POINT, one cycle only:
  - Outputs: `ball_rst`=1, `ball_en`=0.
  - If either score equals `WIN_SCORE`: go to OVER, set `game_over`=1, set `winner`.
  - Otherwise: reload the serve counter, go to SERVE.
- OVER:
  - Outputs: `ball_rst`=1, `ball_en`=0; scores frozen.
  - `start`=1: clear scores, `game_over` and `speed`; go to SERVE.
- Point inputs are ignored in every state except PLAY. This prevents a held point level from being counted twice.
- Scores saturate at 15 and never wrap.
- `start` is ignored in SERVE, PLAY and POINT.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `ball_rst`=1, `ball_en`=0, scores 0, `game_over`=0, `winner`=0, `speed`=0, all counters 0.
- Point in PLAY at edge N:
  - Score updates and state becomes POINT at edge N+1.
  - `ball_rst` is 1 from N+1.
- Serve delay: `ball_rst` falls exactly `SERVE_FRAMES` frame ticks after SERVE is entered. It falls on the edge following the last tick.
- `ball_en` is high for one cycle, one clock after each `frame_tick` while in PLAY. The tick that enters PLAY produces no `ball_en`.
- `frame_tick` and `point` arriving in the same PLAY cycle: the point is taken and `ball_en` is suppressed.
- `reset` asserted mid-match: state and outputs take their reset values immediately, asynchronously. Operation resumes in IDLE on the first edge after release.

## Configuration
- `PONG_SPEEDUP_EN` defined:
  - In PLAY, a rally counter counts frame ticks.
  - Every `RALLY_FRAMES` ticks, `speed` increments, saturating at 3; the counter then restarts.
  - `speed` returns to 0 on every POINT.
- `PONG_SPEEDUP_EN` undefined: no rally counter is built, and `speed` is constant 0.

## Test plan
- Reset, then `start` pulse, `SERVE_FRAMES`=3:
  - Expect IDLE→SERVE.
  - `ball_rst` is 1 through 3 ticks, then falls one clock after the 3rd tick.
  - Scores are 0.
- In PLAY, pulse `point_2`:
  - Expect `score_2`=1 and POINT for one cycle, then SERVE, with `ball_rst`=1 throughout.
  - A `point_1` held high during SERVE does not change `score_1`.
- Assert `point_1` and `point_2` together in PLAY:
  - Expect only `score_1` to increment.
- `WIN_SCORE`=2, two `point_1` pulses:
  - Expect OVER, `game_over`=1, `winner`=0.
  - Further points and ticks leave the scores unchanged.
  - `start` returns to SERVE with scores 0.
- Assert `reset` asynchronously mid-PLAY with `score_1`=5:
  - Expect IDLE, scores 0, `ball_rst`=1 before the next clock edge.
- With `PONG_SPEEDUP_EN`, `RALLY_FRAMES`=2, 8 ticks in PLAY:
  - Expect `speed` 1, 2, 3, 3.
  - A point resets `speed` to 0.
  - Without the macro, `speed` stays 0.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve delay, rally, scoring and winner detection.
// Optional rally speed-up is built only when PONG_SPEEDUP_EN is defined.
module pong_match_ctrl #(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int RALLY_FRAMES = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       point_1,
   input  logic       point_2,
   output logic       ball_rst,
   output logic       ball_en,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic       game_over,
   output logic       winner,
   output logic [1:0] speed,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
   localparam logic [7:0] SRV8 = 8'(SERVE_FRAMES);

   state_t     st;
   logic [7:0] serve_cnt;
   logic       serve_done;

   assign state      = st;
   assign serve_done = frame_tick && (serve_cnt == 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= IDLE;
         ball_rst  <= 1'b1;
         ball_en   <= 1'b0;
         score_1   <= 4'd0;
         score_2   <= 4'd0;
         game_over <= 1'b0;
         winner    <= 1'b0;
         serve_cnt <= 8'd0;
      end else begin
         ball_en <= 1'b0;
         case (st)
            IDLE: begin
               ball_rst <= 1'b1;
               if (start) begin
                  score_1   <= 4'd0;
                  score_2   <= 4'd0;
                  serve_cnt <= SRV8;
                  st        <= SERVE;
               end
            end
            SERVE: begin
               if (serve_done) begin
                  st       <= PLAY;
                  ball_rst <= 1'b0;
               end else if (frame_tick) begin
                  serve_cnt <= serve_cnt - 8'd1;
               end
            end
            PLAY: begin
               // point_1 has priority; a simultaneous tick is swallowed
               if (point_1) begin
                  if (score_1 != 4'd15) score_1 <= score_1 + 4'd1;
                  st       <= POINT;
                  ball_rst <= 1'b1;
               end else if (point_2) begin
                  if (score_2 != 4'd15) score_2 <= score_2 + 4'd1;
                  st       <= POINT;
                  ball_rst <= 1'b1;
               end else begin
                  ball_en <= frame_tick;
               end
            end
            POINT: begin
               if (score_1 == WIN4 || score_2 == WIN4) begin
                  st        <= OVER;
                  game_over <= 1'b1;
                  winner    <= (score_2 == WIN4);
               end else begin
                  serve_cnt <= SRV8;
                  st        <= SERVE;
               end
            end
            OVER: begin
               if (start) begin
                  score_1   <= 4'd0;
                  score_2   <= 4'd0;
                  game_over <= 1'b0;
                  serve_cnt <= SRV8;
                  st        <= SERVE;
               end
            end
            default: begin
               st       <= IDLE;
               ball_rst <= 1'b1;
            end
         endcase
      end
   end

`ifdef PONG_SPEEDUP_EN
   localparam logic [9:0] RALLY_LAST = 10'(RALLY_FRAMES - 1);

   logic [9:0] rally_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rally_cnt <= 10'd0;
         speed     <= 2'd0;
      end else if (st == PLAY) begin
         if (point_1 || point_2) begin
            rally_cnt <= 10'd0;
            speed     <= 2'd0;
         end else if (frame_tick) begin
            if (rally_cnt == RALLY_LAST) begin
               rally_cnt <= 10'd0;
               if (speed != 2'd3) speed <= speed + 2'd1;
            end else begin
               rally_cnt <= rally_cnt + 10'd1;
            end
         end
      end else if (st == SERVE && serve_done) begin
         rally_cnt <= 10'd0;
      end else if ((st == IDLE || st == OVER) && start) begin
         speed <= 2'd0;
      end
   end
`else
   assign speed = (RALLY_FRAMES > 0) ? 2'd0 : 2'd0;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomised bench for pong_match_ctrl against a rule-level match model,
// plus directed checks that pin the model to hand-computed values.
module tb_pong_match_ctrl;
   localparam int WIN = 2;
   localparam int SRV = 3;
   localparam int RAL = 2;

   logic clk = 1'b0, reset = 1'b1;
   logic frame_tick = 1'b0, start = 1'b0, point_1 = 1'b0, point_2 = 1'b0;
   logic ball_rst, ball_en, game_over, winner;
   logic [3:0] score_1, score_2;
   logic [1:0] speed;
   logic [2:0] state;

   int n_tests = 0, n_fail = 0;

   pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .RALLY_FRAMES(RAL)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .point_1(point_1), .point_2(point_2), .ball_rst(ball_rst), .ball_en(ball_en),
      .score_1(score_1), .score_2(score_2), .game_over(game_over), .winner(winner),
      .speed(speed), .state(state)
   );

   always #5 clk = ~clk;

   // Match model: phase number, scores, ticks left before serve, ticks in rally
   int m_phase, m_s1, m_s2, m_left, m_rally, m_go, m_win, m_en;

   function automatic int exp_speed();
`ifdef PONG_SPEEDUP_EN
      return (m_phase == 2) ? ((m_rally / RAL) > 3 ? 3 : m_rally / RAL) : 0;
`else
      return 0;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_rally = 0;
         m_go = 0; m_win = 0; m_en = 0;
      end else begin
         m_en = 0;
         case (m_phase)
            0, 4: if (start) begin
               m_s1 = 0; m_s2 = 0; m_go = 0; m_left = SRV; m_phase = 1;
            end
            1: if (frame_tick) begin
               m_left--;
               if (m_left == 0) begin m_phase = 2; m_rally = 0; end
            end
            2: if (point_1) begin
               m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_phase = 3; m_rally = 0;
            end else if (point_2) begin
               m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_phase = 3; m_rally = 0;
            end else if (frame_tick) begin
               m_en = 1; m_rally++;
            end
            default: if (m_s1 == WIN || m_s2 == WIN) begin
               m_phase = 4; m_go = 1; m_win = (m_s2 == WIN) ? 1 : 0;
            end else begin
               m_phase = 1; m_left = SRV;
            end
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (!reset) begin
         chk("m.state", int'(state), m_phase);
         chk("m.ball_rst", int'(ball_rst), (m_phase == 2) ? 0 : 1);
         chk("m.ball_en", int'(ball_en), m_en);
         chk("m.score_1", int'(score_1), m_s1);
         chk("m.score_2", int'(score_2), m_s2);
         chk("m.game_over", int'(game_over), m_go);
         if (m_go != 0) chk("m.winner", int'(winner), m_win);
         chk("m.speed", int'(speed), exp_speed());
      end
   end

   task automatic cyc(input logic s, input logic t, input logic p1, input logic p2);
      start = s; frame_tick = t; point_1 = p1; point_2 = p2;
      @(posedge clk);
      @(negedge clk);
      start = 0; frame_tick = 0; point_1 = 0; point_2 = 0;
   endtask

   task automatic serve_to_play();
      for (int i = 0; i < SRV; i++) cyc(0, 1, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst.state", int'(state), 0);
      chk("rst.ball_rst", int'(ball_rst), 1);
      chk("rst.ball_en", int'(ball_en), 0);
      chk("rst.scores", int'({score_1, score_2}), 0);
      chk("rst.go_win_spd", int'({game_over, winner, speed}), 0);
      reset = 0;
      @(negedge clk);

      cyc(1, 0, 0, 0);
      chk("start.state", int'(state), 1);
      // point_1 held through the serve must be ignored
      cyc(0, 1, 1, 0);
      cyc(0, 1, 1, 0);
      chk("serve2.ball_rst", int'(ball_rst), 1);
      chk("serve.score_1", int'(score_1), 0);
      cyc(0, 1, 1, 0);
      chk("serve3.ball_rst", int'(ball_rst), 0);
      chk("serve3.state", int'(state), 2);
      chk("serve3.ball_en", int'(ball_en), 0);
      cyc(0, 1, 0, 0);
      chk("play.ball_en", int'(ball_en), 1);
      cyc(0, 0, 0, 0);
      chk("play.ball_en_off", int'(ball_en), 0);
      cyc(0, 1, 0, 1);
      chk("p2.state", int'(state), 3);
      chk("p2.score_2", int'(score_2), 1);
      chk("p2.ball_en", int'(ball_en), 0);
      cyc(0, 0, 0, 0);
      chk("p2.back_serve", int'(state), 1);
      serve_to_play();
      cyc(0, 0, 1, 1);
      chk("both.scores", int'({score_1, score_2}), 8'h11);
      cyc(0, 0, 0, 0);
      serve_to_play();
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, 0, 0);
         cyc(0, 0, 0, 0);
`ifdef PONG_SPEEDUP_EN
         if (i % 2 == 0) chk("speed.step", int'(speed), (i / 2 > 3) ? 3 : i / 2);
`else
         if (i % 2 == 0) chk("speed.zero", int'(speed), 0);
`endif
      end
      cyc(0, 0, 1, 0);
      chk("win.point_speed", int'(speed), 0);
      chk("win.score_1", int'(score_1), 2);
      cyc(0, 0, 0, 0);
      chk("win.state", int'(state), 4);
      chk("win.game_over", int'(game_over), 1);
      chk("win.winner", int'(winner), 0);
      cyc(0, 1, 1, 1);
      chk("over.frozen", int'({score_1, score_2}), 8'h21);
      cyc(1, 0, 0, 0);
      chk("restart.state", int'(state), 1);
      chk("restart.scores", int'({score_1, score_2, game_over}), 0);
      serve_to_play();
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      serve_to_play();

      // asynchronous reset mid-play, checked before the next clock edge
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("arst.state", int'(state), 0);
      chk("arst.ball_rst", int'(ball_rst), 1);
      chk("arst.scores", int'({score_1, score_2}), 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);

      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
